// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, PE origin tables and FSM encoding for the conv window feeder
package conv_pkg;
    localparam int IN_N      = 4;
    localparam int K_N       = 3;
    localparam int OUT_N     = 2;
    localparam int NUM_PE    = 4;
    localparam int NUM_TAPS  = 9;
    localparam int LAST_STEP = 11;
    localparam logic [1:0] PE_I [NUM_PE] = '{2'd0, 2'd0, 2'd1, 2'd1};
    localparam logic [1:0] PE_J [NUM_PE] = '{2'd0, 2'd1, 2'd0, 2'd1};
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/conv_tap_decode.sv
// conv_tap_decode: maps tap index k (0..8) to filter (row, col); ports k_i in, row_o/col_o out
module conv_tap_decode (
    input  logic [3:0] k_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o
);
    always_comb begin
        row_o = (k_i >= 4'd6) ? 2'd2 : (k_i >= 4'd3) ? 2'd1 : 2'd0;
        col_o = (k_i == 4'd1 || k_i == 4'd4 || k_i == 4'd7) ? 2'd1 :
                (k_i == 4'd2 || k_i == 4'd5 || k_i == 4'd8) ? 2'd2 : 2'd0;
    end
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: snapshots a 4x4 tile and 3x3 filter, streams skewed im2col operands to 4 PEs
// Ports: clk, rst (sync active-high), start; a_in/b_in tile and filter; busy, done, w_out/w_valid
// (chain head weight), x_out/x_valid/x_last (per-PE lanes, lane p delayed p cycles).
// FEEDER_BACK_TO_BACK_EN: start in DONE restarts directly into STREAM.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [IN_N*IN_N*DATA_WIDTH-1:0] a_in,
    input  logic [K_N*K_N*DATA_WIDTH-1:0]   b_in,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_WIDTH-1:0]          w_out,
    output logic                           w_valid,
    output logic [NUM_PE*DATA_WIDTH-1:0]   x_out,
    output logic [NUM_PE-1:0]              x_valid,
    output logic [NUM_PE-1:0]              x_last
);
    state_t state_q, state_d;
    logic [3:0] t_q, t_d;
    logic [IN_N*IN_N*DATA_WIDTH-1:0] a_q, a_d;
    logic [K_N*K_N*DATA_WIDTH-1:0] b_q, b_d;
    logic cap, streaming;
    logic [1:0] w_row, w_col;
    logic [3:0] w_idx;
    logic w_hit;
    logic [DATA_WIDTH-1:0] w_d;
    logic [NUM_PE*DATA_WIDTH-1:0] x_d;
    logic [NUM_PE-1:0] xv_d, xl_d;

    always_comb begin
        state_d = state_q;
        t_d = (state_q == S_STREAM) ? t_q + 4'd1 : 4'd0;
        cap = 1'b0;
        if (state_q == S_IDLE) begin
            cap = start;
            state_d = start ? S_STREAM : S_IDLE;
        end else if (state_q == S_STREAM) begin
            state_d = (t_q == 4'(LAST_STEP)) ? S_DONE : S_STREAM;
        end else begin
`ifdef FEEDER_BACK_TO_BACK_EN
            cap = start;
            state_d = start ? S_STREAM : S_IDLE;
`else
            state_d = S_IDLE;
`endif
        end
        a_d = cap ? a_in : a_q;
        b_d = cap ? b_in : b_q;
    end

    // Outputs are registered from next-state values so step t is visible in the cycle after its edge.
    assign streaming = (state_d == S_STREAM);

    conv_tap_decode u_w_dec (.k_i(t_d), .row_o(w_row), .col_o(w_col));
    assign w_idx = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
    assign w_hit = streaming && (t_d <= 4'(NUM_TAPS - 1));
    assign w_d = w_hit ? b_d[DATA_WIDTH*int'(w_idx) +: DATA_WIDTH] : '0;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
        logic [3:0] k, idx;
        logic [1:0] r, c;
        logic hit;
        // Before lane p starts, t-p wraps above 8, so one compare covers both ends.
        assign k = t_d - 4'(p);
        conv_tap_decode u_dec (.k_i(k), .row_o(r), .col_o(c));
        assign idx = {PE_I[p] + r, PE_J[p] + c};
        assign hit = streaming && (k <= 4'(NUM_TAPS - 1));
        assign x_d[DATA_WIDTH*p +: DATA_WIDTH] = hit ? a_d[DATA_WIDTH*int'(idx) +: DATA_WIDTH] : '0;
        assign xv_d[p] = hit;
        assign xl_d[p] = hit && (k == 4'(NUM_TAPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_out   <= '0;
            w_valid <= 1'b0;
            x_out   <= '0;
            x_valid <= '0;
            x_last  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            w_out   <= w_d;
            w_valid <= w_hit;
            x_out   <= x_d;
            x_valid <= xv_d;
            x_last  <= xl_d;
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: scoreboard bench for conv_window_feeder
module tb_conv_window_feeder;
    logic clk = 1'b0;
    logic rst, start;
    logic [127:0] a_in;
    logic [71:0] b_in;
    logic busy, done, w_valid;
    logic [7:0] w_out;
    logic [31:0] x_out;
    logic [3:0] x_valid, x_last;
    logic [50:0] obs, e;
    logic [50:0] q[$];
    logic [127:0] ga;
    logic [71:0] gb;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_window_feeder #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .w_out(w_out), .w_valid(w_valid),
        .x_out(x_out), .x_valid(x_valid), .x_last(x_last)
    );

    assign obs = {busy, done, w_out, w_valid, x_out, x_valid, x_last};

    function automatic logic [50:0] model(input logic [127:0] a, input logic [71:0] b, input int t);
        logic bz, dn, wv;
        logic [7:0] w;
        logic [31:0] x;
        logic [3:0] xv, xl;
        int k, r, c;
        bz = (t <= 12); dn = (t == 12); wv = 0; w = 0; x = 0; xv = 0; xl = 0;
        if (t <= 11) begin
            if (t <= 8) begin w = b[8*t +: 8]; wv = 1; end
            for (int p = 0; p < 4; p++) begin
                k = t - p;
                if (k >= 0 && k <= 8) begin
                    r = p / 2 + k / 3;
                    c = p % 2 + k % 3;
                    x[8*p +: 8] = a[8*(4*r + c) +: 8];
                    xv[p] = 1'b1;
                    xl[p] = (k == 8);
                end
            end
        end
        return {bz, dn, w, wv, x, xv, xl};
    endfunction

    task automatic push_pass(input logic [127:0] a, input logic [71:0] b);
        for (int t = 0; t <= 12; t++) q.push_back(model(a, b, t));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back('0);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        a_in = {$urandom, $urandom, $urandom, $urandom};
        b_in = {$urandom, $urandom, $urandom};
        push_idle(23);
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) begin n_bad++; $display("FAIL reset: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, e); end
            end
            if (i == 2) rst = 1'b0;
        end
    endtask

    task automatic test_golden;
        int acc[4];
        int gold[4];
        logic [7:0] wh[12];
        gold = '{67, 74, 34, 59};
        acc = '{0, 0, 0, 0};
        a_in = ga; b_in = gb; start = 1'b1;
        push_pass(ga, gb); push_idle(1);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (q.size() == 0) begin n_bad++; $display("FAIL golden: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL golden cyc=%0d got=%h exp=%h", i, obs, e); end
            end
            if (i < 12) begin
                wh[i] = w_valid ? w_out : 8'd0;
                for (int p = 0; p < 4; p++)
                    if (x_valid[p] && i >= p) acc[p] += int'(x_out[8*p +: 8]) * int'(wh[i-p]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            n_cmp++;
            if (acc[p] !== gold[p]) begin n_bad++; $display("FAIL golden_sum lane=%0d got=%0d exp=%0d", p, acc[p], gold[p]); end
        end
    endtask

    task automatic test_start_while_busy;
        logic [127:0] a1;
        logic [71:0] b1;
        a1 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom};
        a_in = a1; b_in = b1; start = 1'b1;
        push_pass(a1, b1); push_idle(4);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (q.size() == 0) begin n_bad++; $display("FAIL busy_start: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL busy_start cyc=%0d got=%h exp=%h", i, obs, e); end
            end
            if (i == 3) begin a_in = ~a1; b_in = ~b1; end
            if (i == 5) begin start = 1'b1; a_in = {$urandom, $urandom, $urandom, $urandom}; end
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] a1;
        logic [71:0] b1;
        a1 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom};
        a_in = a1; b_in = b1; start = 1'b1;
        for (int t = 0; t <= 6; t++) q.push_back(model(a1, b1, t));
        push_idle(8);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (q.size() == 0) begin n_bad++; $display("FAIL reset_mid: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, obs, e); end
            end
            rst = (i == 6);
        end
        a1 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom};
        a_in = a1; b_in = b1; start = 1'b1;
        push_pass(a1, b1); push_idle(1);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (q.size() == 0) begin n_bad++; $display("FAIL reset_rerun: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL reset_rerun cyc=%0d got=%h exp=%h", i, obs, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        a_in = ga; b_in = gb; start = 1'b1;
        push_pass(ga, gb);
`ifndef FEEDER_BACK_TO_BACK_EN
        push_idle(1);
`endif
        push_pass(ga, gb); push_idle(2);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) begin n_bad++; $display("FAIL back_to_back: scoreboard empty at %0d", i); end
            else begin
                e = q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs, e); end
            end
            if (i == 14) start = 1'b0;
        end
    endtask

    initial begin
        int gav[16];
        int gbv[9];
        gav = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
        gbv = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
        for (int i = 0; i < 16; i++) ga[8*i +: 8] = 8'(gav[i]);
        for (int i = 0; i < 9; i++) gb[8*i +: 8] = 8'(gbv[i]);
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        test_reset;
        test_golden;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Reader/sequencer on the consumer side of the operand store. Snapshots the parallel 4x4 input tile and 3x3 filter on start.
- Streams them as skewed im2col operands into a 4-PE output-stationary systolic array. Each PE computes one of the 2x2 valid-convolution outputs.
- Weights leave at the chain head. Per-PE data lanes carry a p-cycle skew, with valid and last flags for accumulator control.

Parameters:
- DATA_WIDTH, 8, operand width of every a/b element and output lane.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a new pass; sampled only in IDLE
- a_in  in  16*DATA_WIDTH  input tile, element (r,c) at a_in[DATA_WIDTH*(4*r+c) +: DATA_WIDTH]
- b_in  in  9*DATA_WIDTH  filter, element (r,c) at b_in[DATA_WIDTH*(3*r+c) +: DATA_WIDTH]
- busy  out  1  high in STREAM and DONE
- done  out  1  one-cycle pulse at pass end
- w_out  out  DATA_WIDTH  filter element for the chain head
- w_valid  out  1  w_out valid
- x_out  out  4*DATA_WIDTH  data lane p at x_out[DATA_WIDTH*p +: DATA_WIDTH]
- x_valid  out  4  per-lane valid
- x_last  out  4  per-lane final term (k=8)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: busy=0, done=0, w_out=0, w_valid=0, x_out=0, x_valid=0, x_last=0. State=IDLE, step counter t=0, snapshot registers=0.
- PE mapping: p0=(0,0), p1=(0,1), p2=(1,0), p3=(1,1). The output origin for lane p is (i_p, j_p).
- FSM states: IDLE, STREAM, DONE.
- IDLE: when start=1 at a clock edge, capture a_in/b_in into snapshot registers, set t=0, go to STREAM. Input changes after capture have no effect.
- STREAM: in the cycle with counter value t (0..11), outputs show step t.
  - w_out = b[t/3][t%3], w_valid=1 for t<=8; otherwise w_out=0, w_valid=0.
  - Lane p: k=t-p. If 0<=k<=8, x_out[p] = a[i_p + k/3][j_p + k%3], x_valid[p]=1, x_last[p]=(k==8). Otherwise x_out[p]=0, x_valid[p]=0, x_last[p]=0.
  - t increments each cycle. After t=11, go to DONE.
- DONE: done=1 for exactly one cycle, all valids 0, then IDLE.
- Latency: start accepted at edge E. The first w_valid/x_valid[0] cycle begins at E. The done cycle begins at E+12 edges. Pass length is 13 cycles, start edge to return-to-IDLE edge.
- start while busy is ignored; no queuing.
- No arithmetic. k/3 and k%3 come from a 0..8 index via constant decode or nested row/col counters. No data is modified.
- Reset mid-pass: the next edge forces IDLE and the reset values. No done pulse.
- start and rst together: rst wins.

Optional Feature:
- FEEDER_BACK_TO_BACK_EN defined: in DONE, start=1 recaptures a_in/b_in and enters STREAM with t=0 directly. done still pulses that cycle. Sustained throughput is one pass per 13 cycles.
- Undefined: start in DONE is ignored. At least one IDLE cycle separates passes.

Decomposition:
- Shared package conv_pkg holds:
  - constants IN_N=4, K_N=3, OUT_N=2, NUM_PE=4, NUM_TAPS=9, LAST_STEP=11
  - per-PE origin tables (i_p, j_p)
  - FSM state typedef/encoding
- Sub-module: conv_tap_decode, combinational k (0..8) -> (row, col). Instantiated once for the weight path and once per lane.

Test Plan:
- Reset then idle: rst held 3 cycles then released with start=0 -> all outputs 0, busy=0 for 20 cycles.
- Golden pass: a rows {9,8,2,6},{0,4,1,6},{4,10,1,1},{2,2,9,9}; b rows {3,2,0},{2,0,1},{3,1,1}; pulse start -> expected streams:
  - t=0: w=3, x0=9.
  - t=3: x3=4.
  - t=8: w=1, x0=1 with x_last[0].
  - t=11: x3=9 with x_last[3].
  - done at t=12.
- Golden products: bench multiply-accumulates lane p with w delayed p cycles -> sums 67, 74, 34, 59.
- Start while busy: second start at t=5 with different a_in -> stream unchanged, no extra pass. Change a_in mid-pass -> no effect.
- Reset mid-pass: rst at t=6 -> next cycle all outputs 0, no done. A new start after reset runs a full correct pass.
- Back-to-back (macro on): start held high -> done at cycle 12, next pass t=0 outputs in cycle 13 (w=3). Macro off -> one idle cycle, then restart.
